eco_bist_ctrl: RTL and testbench

//  Parametrised built-in self-test controller for ECO gate-level test cones.
//  - Drives a pseudo-random LFSR stimulus word into an external combinational
//    or pipelined cone, compacts the cone's responses into a MISR signature,
//    and compares that signature with a golden value.
//  - Sits beside each ECO test netlist so pre- and post-ECO cones are checked

---
 rtl/eco_bist_pkg.sv | 21 ++
 rtl/eco_lfsr.sv | 32 +++
 rtl/eco_bist_ctrl.sv | 175 +++++++++++++++++
 tb/tb_eco_bist_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eco_bist_pkg.sv
// Shared types and constants for the ECO cone BIST controller.
// Holds the FSM state type, default feedback masks and the seed fix-up helper.
package eco_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam logic [3:0]  TAPS_W4  = 4'hC;
  localparam logic [9:0]  TAPS_W10 = 10'h240;
  localparam logic [15:0] TAPS_W16 = 16'hB400;

  // An all-zero LFSR state never leaves zero, so a zero seed becomes 1.
  function automatic logic [63:0] fix_seed(input logic [63:0] seed);
    return (seed == 64'd0) ? 64'd1 : seed;
  endfunction

endpackage

// File: rtl/eco_lfsr.sv
// Shift register with XOR feedback: plain Fibonacci LFSR with din=0,
// multiple-input signature register when din carries the cone response.
module eco_lfsr
  import eco_bist_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_W16)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_seed,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_seed;
    end else if (i_en) begin
      r_q <= {r_q[WIDTH-2:0], ^(r_q & TAPS)} ^ i_din;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/eco_bist_ctrl.sv
// BIST controller: streams LFSR patterns into an external cone, compacts the
// responses into a MISR signature and compares it against a golden value.
module eco_bist_ctrl
  import eco_bist_pkg::*;
#(
  parameter int               IN_W      = 10,
  parameter int               OUT_W     = 3,
  parameter int               SIG_W     = 16,
  parameter int               CNT_W     = 16,
  parameter int               PIPE      = 0,
  parameter logic [IN_W-1:0]  LFSR_TAPS = IN_W'(TAPS_W10),
  parameter logic [IN_W-1:0]  LFSR_SEED = IN_W'(1),
  parameter logic [SIG_W-1:0] MISR_TAPS = SIG_W'(TAPS_W16)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [CNT_W-1:0] i_npat,
  input  logic [SIG_W-1:0] i_golden,
  output logic [IN_W-1:0]  o_stim,
  input  logic [OUT_W-1:0] i_y,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [SIG_W-1:0] o_sig
);

  localparam logic [IN_W-1:0] SEED_FIX  = IN_W'(fix_seed(64'(LFSR_SEED)));
  localparam logic [2:0]      DCNT_INIT = (PIPE > 0) ? 3'(PIPE - 1) : 3'd0;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_dcnt;
  logic             r_pass;
  logic             w_start;
  logic             w_issue;
  logic             w_last;
  logic             w_cap;
  logic [IN_W-1:0]  w_stim;
  logic [SIG_W-1:0] w_sig;

  assign w_start = (r_state == IDLE) && i_start && !i_abort;
  assign w_issue = (r_state == RUN);
  assign w_last  = (r_state == RUN) && (r_cnt == CNT_W'(1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          if (i_npat != '0) begin
            w_next = RUN;
          end else begin
            w_next = (PIPE == 0) ? FIN : DRAIN;
          end
        end
      end
      RUN: begin
        if (w_last) begin
          w_next = (PIPE == 0) ? FIN : DRAIN;
        end
      end
      DRAIN: begin
        if (r_dcnt == 3'd0) begin
          w_next = FIN;
        end
      end
      FIN: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
    if (i_abort) begin
      w_next = IDLE;
    end
  end

  // Pattern counter and drain-length counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_dcnt <= '0;
    end else if (i_abort) begin
      r_cnt  <= '0;
      r_dcnt <= '0;
    end else begin
      if (w_start) begin
        r_cnt <= i_npat;
      end else if (r_state == RUN) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if ((w_next == DRAIN) && (r_state != DRAIN)) begin
        r_dcnt <= DCNT_INIT;
      end else if (r_state == DRAIN) begin
        r_dcnt <= r_dcnt - 3'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pass <= 1'b0;
    end else if (i_abort || w_start) begin
      r_pass <= 1'b0;
    end else if (r_state == FIN) begin
      r_pass <= (w_sig == i_golden);
    end
  end

  // Each issued pattern carries a tag down a PIPE-deep pipe so its response is
  // compacted exactly when it leaves the cone.
  generate
    if (PIPE == 0) begin : g_nopipe
      assign w_cap = w_issue;
    end else begin : g_pipe
      logic [PIPE-1:0] r_vpipe;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_vpipe <= '0;
        end else if (i_abort) begin
          r_vpipe <= '0;
        end else begin
          r_vpipe <= (r_vpipe << 1) | PIPE'(w_issue);
        end
      end
      assign w_cap = r_vpipe[PIPE-1];
    end
  endgenerate

  // A zero-length run never loads the LFSR, so STIM keeps its previous value.
  eco_lfsr #(
    .WIDTH (IN_W),
    .TAPS  (LFSR_TAPS)
  ) u_lfsr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_start && (i_npat != '0)),
    .i_seed  (SEED_FIX),
    .i_en    ((r_state == RUN) && !w_last),
    .i_din   ('0),
    .o_q     (w_stim)
  );

  eco_lfsr #(
    .WIDTH (SIG_W),
    .TAPS  (MISR_TAPS)
  ) u_misr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_start),
    .i_seed  ('0),
    .i_en    (w_cap),
    .i_din   (SIG_W'(i_y)),
    .o_q     (w_sig)
  );

  assign o_stim = w_stim;
  assign o_sig  = w_sig;
  assign o_busy = (r_state == RUN) || (r_state == DRAIN);
  assign o_done = (r_state == FIN) && !i_abort;
  assign o_pass = r_pass;

endmodule

// File: tb/tb_eco_bist_ctrl.sv
// Scoreboard bench for eco_bist_ctrl: instance 0 has no cone latency, instance 1
// drives a three-flop cone model; expectations are queued and checked by a monitor.
module tb_eco_bist_ctrl;

  localparam int SEL_STIM = 0;
  localparam int SEL_BUSY = 1;
  localparam int SEL_DONE = 2;
  localparam int SEL_PASS = 3;
  localparam int SEL_SIG  = 4;
  localparam int CYC_LIMIT = 5000;

  localparam logic [3:0] STIM_TBL [15] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                                           4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

  typedef struct {
    int          dut;
    int          doneCyc;
    logic [15:0] sig;
    logic        pass;
    int          busyLen;
  } exp_t;

  typedef struct {
    int          cyc;
    int          dut;
    int          sel;
    logic [31:0] exp;
    string       name;
  } probe_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  start = '0;
  logic [1:0]  abort = '0;
  logic [1:0]  busy;
  logic [1:0]  done;
  logic [1:0]  pass;
  logic [15:0] npat [2];
  logic [15:0] golden [2];
  logic [3:0]  stim [2];
  logic [2:0]  y [2];
  logic [15:0] sig [2];
  logic        yLoopA = 1'b0;
  logic [2:0]  d1, d2, d3;
  int          cyc = 0;
  bit          endReq = 1'b0;

  exp_t        doneQ [$];
  logic [3:0]  stimQ [$];
  probe_t      probeQ [$];
  int          checks = 0;
  int          errors = 0;
  int          busyCnt [2] = '{0, 0};
  bit          pendPass [2] = '{1'b0, 1'b0};
  logic        passExp [2];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    d1  <= stim[1][2:0];
    d2  <= d1;
    d3  <= d2;
  end

  assign y[0] = yLoopA ? stim[0][2:0] : 3'b000;
  assign y[1] = d3;

  eco_bist_ctrl #(
    .IN_W(4), .OUT_W(3), .SIG_W(16), .CNT_W(16), .PIPE(0),
    .LFSR_TAPS(4'hC), .LFSR_SEED(4'h1), .MISR_TAPS(16'hB400)
  ) dutA (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[0]), .i_abort(abort[0]),
    .i_npat(npat[0]), .i_golden(golden[0]), .o_stim(stim[0]), .i_y(y[0]),
    .o_busy(busy[0]), .o_done(done[0]), .o_pass(pass[0]), .o_sig(sig[0])
  );

  eco_bist_ctrl #(
    .IN_W(4), .OUT_W(3), .SIG_W(16), .CNT_W(16), .PIPE(3),
    .LFSR_TAPS(4'hC), .LFSR_SEED(4'h1), .MISR_TAPS(16'hB400)
  ) dutB (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[1]), .i_abort(abort[1]),
    .i_npat(npat[1]), .i_golden(golden[1]), .o_stim(stim[1]), .i_y(y[1]),
    .o_busy(busy[1]), .o_done(done[1]), .o_pass(pass[1]), .o_sig(sig[1])
  );

  function automatic logic [15:0] misrStep(input logic [15:0] s, input logic [2:0] yv);
    return {s[14:0], ^(s & 16'hB400)} ^ {13'd0, yv};
  endfunction

  function automatic logic [3:0] lfsrStep(input logic [3:0] s);
    return {s[2:0], ^(s & 4'hC)};
  endfunction

  function automatic logic [31:0] actualOf(input int d, input int s);
    case (s)
      SEL_STIM: return 32'(stim[d]);
      SEL_BUSY: return 32'(busy[d]);
      SEL_DONE: return 32'(done[d]);
      SEL_PASS: return 32'(pass[d]);
      default:  return 32'(sig[d]);
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  // Only this process compares, so the counters have a single writer.
  always @(negedge clk) begin
    exp_t   e;
    probe_t p;
    for (int d = 0; d < 2; d++) begin
      if (pendPass[d]) begin
        checkOutput($sformatf("pass%0d", d), 32'(pass[d]), 32'(passExp[d]));
        pendPass[d] = 1'b0;
      end
      if (busy[d]) busyCnt[d]++;
      if (done[d]) begin
        checkOutput($sformatf("doneQueued%0d", d), 32'(doneQ.size()), 32'd1);
        if (doneQ.size() > 0) begin
          e = doneQ.pop_front();
          checkOutput($sformatf("doneDut%0d", d), 32'(d), 32'(e.dut));
          checkOutput($sformatf("doneCyc%0d", d), 32'(cyc), 32'(e.doneCyc));
          checkOutput($sformatf("sig%0d", d), 32'(sig[d]), 32'(e.sig));
          checkOutput($sformatf("busyLen%0d", d), 32'(busyCnt[d]), 32'(e.busyLen));
          checkOutput($sformatf("passAtDone%0d", d), 32'(pass[d]), 32'd0);
          pendPass[d] = 1'b1;
          passExp[d]  = e.pass;
        end
        busyCnt[d] = 0;
      end else if (!busy[d]) begin
        busyCnt[d] = 0;
      end
    end
    if (busy[0] && stimQ.size() > 0) begin
      checkOutput("stimA", 32'(stim[0]), 32'(stimQ.pop_front()));
    end
    while (probeQ.size() > 0 && probeQ[0].cyc <= cyc) begin
      p = probeQ.pop_front();
      checkOutput(p.name, actualOf(p.dut, p.sel), p.exp);
    end
    if (cyc > CYC_LIMIT) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout actual=%0d expected<=%0d", cyc, CYC_LIMIT);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
    if (endReq) begin
      checkOutput("pendingDone", 32'(doneQ.size()), 32'd0);
      checkOutput("pendingStim", 32'(stimQ.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  task automatic expectNow(input string name, input int d, input int s, input logic [31:0] e);
    probe_t p;
    p.cyc = cyc; p.dut = d; p.sel = s; p.exp = e; p.name = name;
    probeQ.push_back(p);
  endtask

  task automatic pushStim(input int n);
    for (int i = 0; i < n; i++) stimQ.push_back(STIM_TBL[i]);
  endtask

  // Called one step after a rising edge; START is sampled at the next edge.
  task automatic applyStimulus(input int d, input int n, input logic [15:0] g,
                               input logic [15:0] expSig, input logic expPass,
                               input bit expectDone);
    exp_t e;
    npat[d]   = 16'(n);
    golden[d] = g;
    if (expectDone) begin
      e.dut     = d;
      e.doneCyc = cyc + 1 + n + ((d == 0) ? 0 : 3);
      e.sig     = expSig;
      e.pass    = expPass;
      e.busyLen = n + ((d == 0) ? 0 : 3);
      doneQ.push_back(e);
    end
    start[d] = 1'b1;
    @(posedge clk); #1;
    start[d] = 1'b0;
  endtask

  task automatic waitDone();
    for (int i = 0; i < 400 && doneQ.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] s15, s3, sB;
    logic [3:0]  tv;
    npat[0] = '0; npat[1] = '0; golden[0] = '0; golden[1] = '0;

    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      expectNow("rstStim", d, SEL_STIM, 32'd0);
      expectNow("rstBusy", d, SEL_BUSY, 32'd0);
      expectNow("rstDone", d, SEL_DONE, 32'd0);
      expectNow("rstPass", d, SEL_PASS, 32'd0);
      expectNow("rstSig",  d, SEL_SIG,  32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] full-period run, response looped back");
    yLoopA = 1'b1;
    s15 = '0;
    s3  = '0;
    for (int i = 0; i < 15; i++) begin
      tv  = STIM_TBL[i];
      s15 = misrStep(s15, tv[2:0]);
      if (i < 3) s3 = s15;
    end
    pushStim(15);
    applyStimulus(0, 15, s15, s15, 1'b1, 1'b1);
    waitDone();
    expectNow("stimHoldA", 0, SEL_STIM, 32'h8);

    $display("[TB] zero-pattern run");
    applyStimulus(0, 0, 16'h0, 16'h0, 1'b1, 1'b1);
    waitDone();
    expectNow("stimKeptA", 0, SEL_STIM, 32'h8);

    $display("[TB] abort during FIN");
    applyStimulus(0, 3, s3, 16'h0, 1'b0, 1'b0);
    repeat (3) @(posedge clk); #1;
    abort[0] = 1'b1;
    expectNow("doneAbortFin", 0, SEL_DONE, 32'd0);
    @(posedge clk); #1;
    abort[0] = 1'b0;
    expectNow("passAbortFin", 0, SEL_PASS, 32'd0);
    expectNow("sigKeptAbort", 0, SEL_SIG, 32'(s3));
    expectNow("busyAbortFin", 0, SEL_BUSY, 32'd0);
    repeat (3) @(posedge clk); #1;

    $display("[TB] abort on fifth RUN cycle then restart");
    pushStim(5);
    applyStimulus(0, 15, 16'h0, 16'h0, 1'b0, 1'b0);
    repeat (4) @(posedge clk); #1;
    abort[0] = 1'b1;
    @(posedge clk); #1;
    abort[0] = 1'b0;
    expectNow("busyAbortRun", 0, SEL_BUSY, 32'd0);
    expectNow("doneAbortRun", 0, SEL_DONE, 32'd0);
    pushStim(15);
    applyStimulus(0, 15, s15, s15, 1'b1, 1'b1);
    waitDone();

    $display("[TB] response tied low");
    yLoopA = 1'b0;
    applyStimulus(0, 100, 16'h0, 16'h0, 1'b1, 1'b1);
    waitDone();
    applyStimulus(0, 100, 16'h1, 16'h0, 1'b0, 1'b1);
    waitDone();

    $display("[TB] three-cycle cone, START pulsed while busy");
    sB = '0;
    tv = 4'h1;
    for (int i = 0; i < 20; i++) begin
      sB = misrStep(sB, tv[2:0]);
      tv = lfsrStep(tv);
    end
    applyStimulus(1, 20, sB, sB, 1'b1, 1'b1);
    repeat (5) @(posedge clk); #1;
    start[1] = 1'b1;
    @(posedge clk); #1;
    start[1] = 1'b0;
    waitDone();
    expectNow("sigHeldB", 1, SEL_SIG, 32'(sB));
    applyStimulus(1, 0, 16'h0, 16'h0, 1'b1, 1'b1);
    waitDone();

    $display("[TB] reset asserted during DRAIN");
    applyStimulus(1, 4, 16'h0, 16'h0, 1'b0, 1'b0);
    repeat (5) @(posedge clk); #2;
    rst_n = 1'b0;
    expectNow("midRstStim", 1, SEL_STIM, 32'd0);
    expectNow("midRstBusy", 1, SEL_BUSY, 32'd0);
    expectNow("midRstDone", 1, SEL_DONE, 32'd0);
    expectNow("midRstPass", 1, SEL_PASS, 32'd0);
    expectNow("midRstSig",  1, SEL_SIG,  32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] START and ABORT together in IDLE");
    npat[1]  = 16'd5;
    start[1] = 1'b1;
    abort[1] = 1'b1;
    @(posedge clk); #1;
    start[1] = 1'b0;
    abort[1] = 1'b0;
    expectNow("busyStartAbort", 1, SEL_BUSY, 32'd0);
    expectNow("stimStartAbort", 1, SEL_STIM, 32'd0);
    repeat (10) @(posedge clk); #1;
    expectNow("busyStartAbortLater", 1, SEL_BUSY, 32'd0);
    @(posedge clk); #1;
    endReq = 1'b1;
  end

endmodule
